// File: rtl/fft_stage_sequencer_pkg.sv
// Shared types and helpers for the FFT stage sequencer.
// Holds the controller state encoding, the stage-index width helper
// and the bit-reversal function used for decimation-in-time load order.
package fft_seq_pkg;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      COMPUTE = 2'd1,
      UNLOAD  = 2'd2
   } fft_state_e;

   // Widest address the bit-reversal helper handles (65536-point frames).
   localparam int unsigned MAX_BITS = 16;

   // Width of the stage index: one bit minimum even for a single stage.
   function automatic int unsigned stage_w_f(input int unsigned stages);
      return (stages > 32'd1) ? $clog2(stages) : 32'd1;
   endfunction

   // Reverse the low nbits of value; bits above nbits come back as zero.
   function automatic logic [MAX_BITS-1:0] bitrev(input logic [MAX_BITS-1:0] value,
                                                  input int unsigned       nbits);
      logic [MAX_BITS-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < MAX_BITS; i++) begin
         if (i < nbits) begin
            r[i] = value[nbits-32'd1-i];
         end else begin
            r[i] = 1'b0;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Streaming sample interface of the FFT stage sequencer.
// Carries the input sample handshake and the output bin handshake.
// The controller takes the slave view; the surrounding system the master view.
interface fft_stage_sequencer_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/fft_frame_buffer.sv
// Frame register array for the FFT stage sequencer.
// Priority: synchronous clear, then whole-frame stage write, then single-word load.
// Reads are a plain mux of the registered words.
module fft_frame_buffer #(
   parameter int unsigned SAMPLES = 4,
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned AW      = $clog2(SAMPLES)
) (
   input  logic                           clk,
   input  logic                           clr_i,
   input  logic                           wr_en_i,
   input  logic [AW-1:0]                  wr_addr_i,
   input  logic [WIDTH-1:0]               wr_data_i,
   input  logic                           ld_en_i,
   input  logic [SAMPLES-1:0][WIDTH-1:0]  ld_data_i,
   input  logic [AW-1:0]                  rd_addr_i,
   output logic [WIDTH-1:0]               rd_data_o,
   output logic [SAMPLES-1:0][WIDTH-1:0]  frame_o
);

   logic [SAMPLES-1:0][WIDTH-1:0] mem_q;

   // Frame storage: clear, stage result capture, or single sample load.
   always_ff @(posedge clk) begin
      if (clr_i) begin
         mem_q <= '0;
      end else if (ld_en_i) begin
         mem_q <= ld_data_i;
      end else if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end else begin
         mem_q <= mem_q;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];
   assign frame_o   = mem_q;

endmodule

// File: rtl/fft_stage_sequencer.sv
// Iterative FFT controller: loads one frame, runs it through STAGES
// external butterfly stages (one per cycle), then streams the bins out.
// Optional macro FFT_SEQ_BITREV_EN: when defined, samples are stored at the
// bit-reversed address of their arrival index (decimation-in-time order);
// when undefined, upstream is expected to supply pre-reversed data.
module fft_stage_sequencer
   import fft_seq_pkg::*;
#(
   parameter int unsigned SAMPLES = 4,
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned STAGES  = $clog2(SAMPLES),
   parameter int unsigned STAGE_W = stage_w_f(STAGES)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   fft_stage_sequencer_if.slave           io,
   output logic [SAMPLES-1:0][WIDTH-1:0]  stage_data_o,
   output logic [STAGE_W-1:0]             stage_idx,
   input  logic [SAMPLES-1:0][WIDTH-1:0]  stage_data_i,
   output logic                           busy,
   output logic                           frame_done
);

   localparam int unsigned      AW         = $clog2(SAMPLES);
   localparam logic [AW-1:0]    LAST_IDX   = AW'(SAMPLES - 32'd1);
   localparam logic [AW-1:0]    PRE_LAST   = AW'(SAMPLES - 32'd2);
   localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(STAGES - 32'd1);

   fft_state_e          state_q;
   logic [AW-1:0]       wr_cnt_q;
   logic [AW-1:0]       rd_cnt_q;
   logic [STAGE_W-1:0]  stage_idx_q;
   logic                in_ready_q;
   logic                busy_q;
   logic                out_valid_q;
   logic                out_last_q;

   logic                buf_clr;
   logic                buf_wr_en;
   logic [AW-1:0]       buf_wr_addr;
   logic                buf_ld_en;
   logic [WIDTH-1:0]    buf_rd_data;

   // Controller FSM with counters and registered handshake/status flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= LOAD;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         stage_idx_q <= '0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         case (state_q)
            LOAD: begin
               if (io.in_valid) begin
                  if (wr_cnt_q == LAST_IDX) begin
                     wr_cnt_q    <= '0;
                     stage_idx_q <= '0;
                     state_q     <= COMPUTE;
                     in_ready_q  <= 1'b0;
                     busy_q      <= 1'b1;
                  end else begin
                     wr_cnt_q <= wr_cnt_q + 1'b1;
                  end
               end
            end
            COMPUTE: begin
               if (stage_idx_q == LAST_STAGE) begin
                  stage_idx_q <= '0;
                  state_q     <= UNLOAD;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
                  out_last_q  <= 1'b0;
               end else begin
                  stage_idx_q <= stage_idx_q + 1'b1;
               end
            end
            UNLOAD: begin
               if (io.out_ready) begin
                  if (rd_cnt_q == LAST_IDX) begin
                     rd_cnt_q    <= '0;
                     state_q     <= LOAD;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     in_ready_q  <= 1'b1;
                  end else begin
                     rd_cnt_q   <= rd_cnt_q + 1'b1;
                     out_last_q <= (rd_cnt_q == PRE_LAST);
                  end
               end
            end
            default: begin
               state_q     <= LOAD;
               wr_cnt_q    <= '0;
               rd_cnt_q    <= '0;
               stage_idx_q <= '0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
               out_valid_q <= 1'b0;
               out_last_q  <= 1'b0;
            end
         endcase
      end
   end

   // Buffer write controls decoded from the registered state.
   always_comb begin
      buf_clr   = !rst_n;
      buf_wr_en = (state_q == LOAD) && io.in_valid;
      buf_ld_en = (state_q == COMPUTE);
`ifdef FFT_SEQ_BITREV_EN
      buf_wr_addr = AW'(bitrev(MAX_BITS'(wr_cnt_q), AW));
`else
      buf_wr_addr = wr_cnt_q;
`endif
   end

   fft_frame_buffer #(
      .SAMPLES (SAMPLES),
      .WIDTH   (WIDTH),
      .AW      (AW)
   ) u_frame_buffer (
      .clk       (clk),
      .clr_i     (buf_clr),
      .wr_en_i   (buf_wr_en),
      .wr_addr_i (buf_wr_addr),
      .wr_data_i (io.in_data),
      .ld_en_i   (buf_ld_en),
      .ld_data_i (stage_data_i),
      .rd_addr_i (rd_cnt_q),
      .rd_data_o (buf_rd_data),
      .frame_o   (stage_data_o)
   );

   assign io.in_ready  = in_ready_q;
   assign io.out_valid = out_valid_q;
   assign io.out_data  = buf_rd_data;
   assign io.out_last  = out_last_q;
   assign stage_idx    = stage_idx_q;
   assign busy         = busy_q;
   // Pulses in the cycle the last bin is actually taken downstream.
   assign frame_done   = out_valid_q && io.out_ready && out_last_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer with a +1-per-stage stub datapath.
// A 4-point instance covers load order, staging, backpressure, input gaps and
// mid-frame reset; an 8-point instance covers back-to-back frame timing.
module tb_fft_stage_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- 4-point instance ----------------
   fft_stage_sequencer_if #(.WIDTH(32)) if4 ();
   logic [3:0][31:0] sdo4, sdi4;
   logic [0:0]       sidx4;
   logic             busy4, done4_p;

   always_comb begin
      for (int k = 0; k < 4; k++) sdi4[k] = sdo4[k] + 32'd1;
   end

   fft_stage_sequencer #(.SAMPLES(4), .WIDTH(32)) dut4 (
      .clk          (clk),
      .rst_n        (rst_n),
      .io           (if4),
      .stage_data_o (sdo4),
      .stage_idx    (sidx4),
      .stage_data_i (sdi4),
      .busy         (busy4),
      .frame_done   (done4_p)
   );

   // ---------------- 8-point instance ----------------
   fft_stage_sequencer_if #(.WIDTH(32)) if8 ();
   logic [7:0][31:0] sdo8, sdi8;
   logic [1:0]       sidx8;
   logic             busy8, done8_p;

   always_comb begin
      for (int k = 0; k < 8; k++) sdi8[k] = sdo8[k] + 32'd1;
   end

   fft_stage_sequencer #(.SAMPLES(8), .WIDTH(32)) dut8 (
      .clk          (clk),
      .rst_n        (rst_n),
      .io           (if8),
      .stage_data_o (sdo8),
      .stage_idx    (sidx8),
      .stage_data_i (sdi8),
      .busy         (busy8),
      .frame_done   (done8_p)
   );

   // Edge counters for pulses and busy cycles.
   int cyc = 0;
   int done4_n = 0;
   int busy4_n = 0;
   int done8_n = 0;
   int busy8_n = 0;
   int t8 [3];
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (done4_p) done4_n = done4_n + 1;
      if (busy4)   busy4_n = busy4_n + 1;
      if (busy8)   busy8_n = busy8_n + 1;
      if (done8_p) begin
         if (done8_n < 3) t8[done8_n] = cyc;
         done8_n = done8_n + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Storage address of the k-th arriving sample.
   function automatic int addr_m(input int k);
      logic [1:0] kk;
      kk = k[1:0];
`ifdef FFT_SEQ_BITREV_EN
      return int'({kk[0], kk[1]});
`else
      return int'(kk);
`endif
   endfunction

   logic [31:0] in_vals [4];
   logic [31:0] exp_buf [4];

   task automatic set_frame(input logic [31:0] v0, v1, v2, v3);
      in_vals[0] = v0; in_vals[1] = v1; in_vals[2] = v2; in_vals[3] = v3;
      for (int i = 0; i < 4; i++) exp_buf[addr_m(i)] = in_vals[i];
   endtask

   task automatic load_frame(input bit gaps);
      for (int i = 0; i < 4; i++) begin
         if4.in_valid = 1'b1;
         if4.in_data  = in_vals[i];
         @(posedge clk); #1;
         if (gaps && i < 3) begin
            if4.in_valid = 1'b0;
            if4.in_data  = 32'hBAD0_0BAD;
            @(posedge clk); #1;
            check("gap_in_ready", {31'd0, if4.in_ready}, 32'd1);
            check("gap_busy", {31'd0, busy4}, 32'd0);
         end
      end
      if4.in_valid = 1'b0;
   endtask

   task automatic compute_phase();
      check("c0_stage_idx", {31'd0, sidx4}, 32'd0);
      check("c0_busy", {31'd0, busy4}, 32'd1);
      check("c0_in_ready", {31'd0, if4.in_ready}, 32'd0);
      check("c0_out_valid", {31'd0, if4.out_valid}, 32'd0);
      for (int k = 0; k < 4; k++)
         check($sformatf("c0_stage_data_o[%0d]", k), sdo4[k], exp_buf[k]);
      // Junk offered outside LOAD must not be captured.
      if4.in_valid = 1'b1;
      if4.in_data  = 32'hFFFF_FFF0;
      @(posedge clk); #1;
      check("c1_stage_idx", {31'd0, sidx4}, 32'd1);
      check("c1_busy", {31'd0, busy4}, 32'd1);
      for (int k = 0; k < 4; k++)
         check($sformatf("c1_stage_data_o[%0d]", k), sdo4[k], exp_buf[k] + 32'd1);
      @(posedge clk); #1;
      check("u_busy", {31'd0, busy4}, 32'd0);
      check("u_in_ready", {31'd0, if4.in_ready}, 32'd0);
      check("u_stage_idx", {31'd0, sidx4}, 32'd0);
      if4.in_valid = 1'b0;
   endtask

   task automatic unload_phase(input int stall_at);
      int d0;
      d0 = done4_n;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("out_valid[%0d]", k), {31'd0, if4.out_valid}, 32'd1);
         check($sformatf("out_data[%0d]", k), if4.out_data, exp_buf[k] + 32'd2);
         check($sformatf("out_last[%0d]", k), {31'd0, if4.out_last}, (k == 3) ? 32'd1 : 32'd0);
         if (k == stall_at) begin
            if4.out_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               @(posedge clk); #1;
               check("stall_out_data", if4.out_data, exp_buf[k] + 32'd2);
               check("stall_out_valid", {31'd0, if4.out_valid}, 32'd1);
               check("stall_frame_done", {31'd0, done4_p}, 32'd0);
            end
            if4.out_ready = 1'b1;
            #1;
         end
         check($sformatf("frame_done[%0d]", k), {31'd0, done4_p}, (k == 3) ? 32'd1 : 32'd0);
         @(posedge clk); #1;
      end
      check("post_out_valid", {31'd0, if4.out_valid}, 32'd0);
      check("post_in_ready", {31'd0, if4.in_ready}, 32'd1);
      check("post_frame_done", {31'd0, done4_p}, 32'd0);
      check("frame_done_pulses", done4_n - d0, 32'd1);
   endtask

   initial begin
      int b0;
      if4.in_valid  = 1'b0;
      if4.in_data   = 32'd0;
      if4.out_ready = 1'b1;
      if8.in_valid  = 1'b0;
      if8.in_data   = 32'd0;
      if8.out_ready = 1'b1;

      // Reset state
      rst_n = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check("rst_in_ready", {31'd0, if4.in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, if4.out_valid}, 32'd0);
      check("rst_out_last", {31'd0, if4.out_last}, 32'd0);
      check("rst_busy", {31'd0, busy4}, 32'd0);
      check("rst_stage_idx", {31'd0, sidx4}, 32'd0);
      check("rst_frame_done", {31'd0, done4_p}, 32'd0);
      check("rst_buf0", sdo4[0], 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Frame 1: plain load, no backpressure
      set_frame(32'd10, 32'd20, 32'd30, 32'd40);
      b0 = busy4_n;
      load_frame(1'b0);
      compute_phase();
      unload_phase(-1);
      check("busy_cycles_f1", busy4_n - b0, 32'd2);

      // Frame 2: input gaps plus 3-cycle stall at rd_cnt=1
      set_frame(32'd10, 32'd20, 32'd30, 32'd40);
      b0 = busy4_n;
      load_frame(1'b1);
      compute_phase();
      unload_phase(1);
      check("busy_cycles_f2", busy4_n - b0, 32'd2);

      // Frame 3: reset after two samples, then a fresh frame
      if4.in_valid = 1'b1; if4.in_data = 32'd111;
      @(posedge clk); #1;
      if4.in_data = 32'd222;
      @(posedge clk); #1;
      if4.in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("mrst_in_ready", {31'd0, if4.in_ready}, 32'd1);
      check("mrst_busy", {31'd0, busy4}, 32'd0);
      check("mrst_out_valid", {31'd0, if4.out_valid}, 32'd0);
      for (int k = 0; k < 4; k++)
         check($sformatf("mrst_buf[%0d]", k), sdo4[k], 32'd0);
      set_frame(32'd100, 32'd200, 32'd300, 32'd400);
      load_frame(1'b0);
      compute_phase();
      unload_phase(-1);

      // Back-to-back 8-point frames
      if8.in_valid  = 1'b1;
      if8.in_data   = 32'd7;
      if8.out_ready = 1'b1;
      for (int c = 0; c < 120 && done8_n < 3; c++) begin
         @(posedge clk); #1;
      end
      check("b2b_frames_done", done8_n, 32'd3);
      check("b2b_period_1", t8[1] - t8[0], 32'd19);
      check("b2b_period_2", t8[2] - t8[1], 32'd19);
      check("b2b_busy_cycles", busy8_n, 32'd9);
      if8.in_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
